tcam_ctrl: RTL

//  Command sequencer and arbiter in front of the 4-block TCAM macro wrapper (28-bit search key, 6-bit PMA).

---
 rtl/tcam_pkg.sv | 32 +++
 rtl/tcam_ctrl_if.sv | 49 ++++
 rtl/tcam_rr_arb2.sv | 38 +++
 rtl/tcam_ctrl.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/tcam_pkg.sv
`default_nettype none
// ============================================================================
// Package  : tcam_pkg
// Brief    : Shared widths, FSM state type and helpers for the TCAM controller.
// Revision : 1.0
// ============================================================================
package tcam_pkg;

    localparam int TCAM_ADDR_W  = 28;
    localparam int TCAM_DATA_W  = 32;
    localparam int TCAM_PMA_W   = 6;
    localparam int TCAM_NBLK    = 4;
    localparam int TCAM_ROWS    = 256;
    localparam int TCAM_WADDR_W = 10;
    localparam int TCAM_MASK_W  = TCAM_DATA_W / 8;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CLEAR      = 3'd1,
        ST_WRITE      = 3'd2,
        ST_SRCH_ISSUE = 3'd3,
        ST_SRCH_WAIT  = 3'd4,
        ST_RESP       = 3'd5
    } tcam_ctrl_state_e;

    // Row addresses occupy the low bits of the macro address bus.
    function automatic logic [TCAM_ADDR_W-1:0] tcam_waddr(input logic [TCAM_WADDR_W-1:0] a);
        return {{(TCAM_ADDR_W-TCAM_WADDR_W){1'b0}}, a};
    endfunction

endpackage
`default_nettype wire

// File: rtl/tcam_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface: tcam_ctrl_if
// Brief    : Requester, response, clear and macro-pin signals of tcam_ctrl.
// Revision : 1.0
// ============================================================================
interface tcam_ctrl_if;
    import tcam_pkg::*;

    logic                    wr_valid;
    logic                    wr_ready;
    logic [TCAM_WADDR_W-1:0] wr_addr;
    logic [TCAM_MASK_W-1:0]  wr_wmask;
    logic [TCAM_DATA_W-1:0]  wr_wdata;

    logic                    srch_valid;
    logic                    srch_ready;
    logic [TCAM_ADDR_W-1:0]  srch_key;

    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [TCAM_PMA_W-1:0]   rsp_pma;

    logic                    clr_start;
    logic                    clr_busy;

    logic                    tcam_csb;
    logic                    tcam_web;
    logic [TCAM_MASK_W-1:0]  tcam_wmask;
    logic [TCAM_ADDR_W-1:0]  tcam_addr;
    logic [TCAM_DATA_W-1:0]  tcam_wdata;
    logic [TCAM_PMA_W-1:0]   tcam_pma;

    modport slave (
        input  wr_valid, wr_addr, wr_wmask, wr_wdata,
        input  srch_valid, srch_key, rsp_ready, clr_start, tcam_pma,
        output wr_ready, srch_ready, rsp_valid, rsp_pma, clr_busy,
        output tcam_csb, tcam_web, tcam_wmask, tcam_addr, tcam_wdata
    );

    modport master (
        output wr_valid, wr_addr, wr_wmask, wr_wdata,
        output srch_valid, srch_key, rsp_ready, clr_start, tcam_pma,
        input  wr_ready, srch_ready, rsp_valid, rsp_pma, clr_busy,
        input  tcam_csb, tcam_web, tcam_wmask, tcam_addr, tcam_wdata
    );

endinterface
`default_nettype wire

// File: rtl/tcam_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : tcam_rr_arb2
// Brief    : Two-requester round-robin arbiter, one-hot grant (bit 0 = write).
// Revision : 1.0
// ============================================================================
module tcam_rr_arb2 (
    input  wire        in_clk,
    input  wire        in_rst,
    input  wire        i_en,
    input  wire  [1:0] i_req,
    output logic [1:0] o_gnt
);

    logic r_pref_srch;

    always_comb begin
        o_gnt = 2'b00;
        if (i_en) begin
            if (i_req == 2'b11) begin
                o_gnt = r_pref_srch ? 2'b10 : 2'b01;
            end else begin
                o_gnt = i_req;
            end
        end
    end

    // A grant is an accept, so the pointer moves to the requester not served.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_pref_srch <= 1'b0;
        end else if (|o_gnt) begin
            r_pref_srch <= o_gnt[0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/tcam_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tcam_ctrl
// Brief    : Shares the TCAM macro port between writes and searches and runs
//            the full-array clear sweep.
// Revision : 1.0
// ============================================================================
module tcam_ctrl
    import tcam_pkg::*;
#(
    parameter int SEARCH_LAT     = 1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input wire         in_clk,
    input wire         in_rst,
    tcam_ctrl_if.slave bus
);

    localparam logic [2:0]              c_last_wait = 3'(SEARCH_LAT - 1);
    localparam logic [TCAM_WADDR_W-1:0] c_last_row  = TCAM_WADDR_W'(TCAM_NBLK * TCAM_ROWS - 1);

    tcam_ctrl_state_e        r_state;
    logic [TCAM_WADDR_W-1:0] r_clr_cnt;
    logic                    r_clr_last;
    logic [2:0]              r_wait_cnt;

    logic                    r_csb;
    logic                    r_web;
    logic [TCAM_MASK_W-1:0]  r_wmask;
    logic [TCAM_ADDR_W-1:0]  r_addr;
    logic [TCAM_DATA_W-1:0]  r_wdata;
    logic                    r_rsp_valid;
    logic [TCAM_PMA_W-1:0]   r_rsp_pma;
    logic                    r_clr_busy;

    logic                    w_grant_en;
    logic [1:0]              w_gnt;

    // clr_start outranks both requesters in IDLE.
    assign w_grant_en = (r_state == ST_IDLE) && !bus.clr_start;

    tcam_rr_arb2 u_arb (
        .in_clk (in_clk),
        .in_rst (in_rst),
        .i_en   (w_grant_en),
        .i_req  ({bus.srch_valid, bus.wr_valid}),
        .o_gnt  (w_gnt)
    );

    assign bus.wr_ready   = w_gnt[0];
    assign bus.srch_ready = w_gnt[1];
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_pma    = r_rsp_pma;
    assign bus.clr_busy   = r_clr_busy;
    assign bus.tcam_csb   = r_csb;
    assign bus.tcam_web   = r_web;
    assign bus.tcam_wmask = r_wmask;
    assign bus.tcam_addr  = r_addr;
    assign bus.tcam_wdata = r_wdata;

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_state     <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            r_clr_cnt   <= '0;
            r_clr_last  <= 1'b0;
            r_wait_cnt  <= '0;
            r_csb       <= 1'b1;
            r_web       <= 1'b1;
            r_wmask     <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_pma   <= '0;
            r_clr_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.clr_start) begin
                        r_clr_cnt  <= '0;
                        r_clr_last <= 1'b0;
                        r_state    <= ST_CLEAR;
                    end else if (w_gnt[0]) begin
                        r_csb   <= 1'b0;
                        r_web   <= 1'b0;
                        r_wmask <= bus.wr_wmask;
                        r_addr  <= tcam_waddr(bus.wr_addr);
                        r_wdata <= bus.wr_wdata;
                        r_state <= ST_WRITE;
                    end else if (w_gnt[1]) begin
                        r_csb   <= 1'b0;
                        r_web   <= 1'b1;
                        r_wmask <= '0;
                        r_addr  <= bus.srch_key;
                        r_state <= ST_SRCH_ISSUE;
                    end
                end
                ST_WRITE: begin
                    r_csb   <= 1'b1;
                    r_web   <= 1'b1;
                    r_state <= ST_IDLE;
                end
                ST_SRCH_ISSUE: begin
                    r_csb      <= 1'b1;
                    r_wait_cnt <= '0;
                    r_state    <= ST_SRCH_WAIT;
                end
                ST_SRCH_WAIT: begin
                    if (r_wait_cnt == c_last_wait) begin
                        r_rsp_pma   <= bus.tcam_pma;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 3'd1;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                ST_CLEAR: begin
                    // r_clr_last marks that the final row is on the pins this cycle.
                    if (r_clr_last) begin
                        r_csb      <= 1'b1;
                        r_web      <= 1'b1;
                        r_clr_busy <= 1'b0;
                        r_clr_last <= 1'b0;
                        r_clr_cnt  <= '0;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_csb      <= 1'b0;
                        r_web      <= 1'b0;
                        r_wmask    <= '1;
                        r_wdata    <= '0;
                        r_addr     <= tcam_waddr(r_clr_cnt);
                        r_clr_busy <= 1'b1;
                        r_clr_last <= (r_clr_cnt == c_last_row);
                        r_clr_cnt  <= r_clr_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
